// File: rtl/iic_pkg.sv
// ---------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the write-only I2C responder (iic_slave_rx):
//   state_e    - receive FSM states
//   CTRL_DATA  - control byte announcing a data stream (D/C = 1)
//   CTRL_CMD   - control byte announcing a command stream (D/C = 0)
//   OLED_ADDR  - default 8-bit address byte (7-bit 0x3C plus write bit 0)
//   DC_BIT     - position of the D/C flag inside the control byte
// ---------------------------------------------------------------------------
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CTRL_DATA = 8'h40;
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] OLED_ADDR = 8'h78;
    localparam int         DC_BIT    = 6;

endpackage

// File: rtl/iic_slave_rx_if.sv
// ---------------------------------------------------------------------------
// iic_slave_rx_if
// Bus and fabric-side signals of iic_slave_rx.
//   scl, sda_in  : I2C lines as seen on the bus (driven by the master side)
//   sda_oe       : 1 = responder pulls SDA low (open-drain)
//   rx_data      : last received data byte
//   rx_dc        : D/C flag of rx_data (control byte bit 6)
//   rx_valid     : one-cycle pulse, rx_data/rx_dc valid
//   rx_stop      : one-cycle pulse on STOP ending an addressed transaction
//   addr_err     : one-cycle pulse when the address byte is NACKed
//   busy         : high from matched address ACK to STOP
// Modports: master (bus driver / fabric consumer), slave (the responder).
// ---------------------------------------------------------------------------
interface iic_slave_rx_if;

    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;
    logic       rx_stop;
    logic       addr_err;
    logic       busy;

    modport master (
        output scl, sda_in,
        input  sda_oe, rx_data, rx_dc, rx_valid, rx_stop, addr_err, busy
    );

    modport slave (
        input  scl, sda_in,
        output sda_oe, rx_data, rx_dc, rx_valid, rx_stop, addr_err, busy
    );

endinterface

// File: rtl/iic_line_cond.sv
// ---------------------------------------------------------------------------
// iic_line_cond
// Conditions one asynchronous I2C line for use in the clk domain: 2-flop
// synchronizer, optional glitch filter, level and edge outputs.
// Optional feature macro: IIC_GLITCH_FILTER_EN - when defined, the level
// only changes after FILT_LEN consecutive identical synchronized samples.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   line_i    : raw bus line
//   level_o   : conditioned level
//   rise_o    : one-cycle pulse on a conditioned 0->1 transition
//   fall_o    : one-cycle pulse on a conditioned 1->0 transition
// ---------------------------------------------------------------------------
module iic_line_cond #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, prev_q;
    logic level;

    // Idle I2C lines are high, so the pipeline resets to 1 to avoid a
    // false edge when reset is released on an idle bus.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge value, which is what makes this a real 2-stage chain.
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef IIC_GLITCH_FILTER_EN
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered
    // level; the level flips on the FILT_LEN-th one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/iic_slave_rx.sv
// ---------------------------------------------------------------------------
// iic_slave_rx
// Write-only I2C responder: detects START/STOP, matches SLAVE_ADDR, ACKs
// the address, control and data bytes, and hands each data byte with its
// D/C flag (control byte bit 6) to fabric logic. SCL/SDA are oversampled
// on clk; nothing is clocked by SCL.
// Optional feature macro: IIC_GLITCH_FILTER_EN (glitch filter of FILT_LEN
// samples on both lines, see iic_line_cond).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : iic_slave_rx_if.slave (scl, sda_in in; sda_oe, rx_data, rx_dc,
//          rx_valid, rx_stop, addr_err, busy out)
// ---------------------------------------------------------------------------
module iic_slave_rx
    import iic_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = OLED_ADDR,
    parameter int         FILT_LEN   = 4
) (
    input  logic         clk,
    input  logic         rst,
    iic_slave_rx_if.slave bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_line_cond #(.FILT_LEN(FILT_LEN)) u_scl_cond (
        .clk(clk), .rst(rst), .line_i(bus.scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    iic_line_cond #(.FILT_LEN(FILT_LEN)) u_sda_cond (
        .clk(clk), .rst(rst), .line_i(bus.sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    // Both lines share the same pipeline delay, so the SCL level seen
    // alongside an SDA edge is the one the bus had at that moment.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_dc_q, rx_dc_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_stop_q, rx_stop_d;
    logic       addr_err_q, addr_err_d;
    logic       busy_q, busy_d;

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rx_dc_d    = rx_dc_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_stop_d  = 1'b0;
        addr_err_d = 1'b0;

        if (start_det) begin
            // Repeated START restarts address decode; partial byte dropped.
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            rx_stop_d = busy_q;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_CTRL, ST_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // Falling edge after the 8th bit opens the ACK slot.
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q == SLAVE_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d    = ST_IGNORE;
                                addr_err_d = 1'b1;
                            end
                        end else if (state_q == ST_CTRL) begin
                            state_d  = ST_CTRL_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d    = ST_DATA_ACK;
                            sda_oe_d   = 1'b1;
                            rx_valid_d = 1'b1;
                            rx_data_d  = shift_q;
                        end
                    end
                end
                ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
                    // Hold the ACK through the 9th SCL high; release on its fall.
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ST_ADDR_ACK) ? ST_CTRL : ST_DATA;
                        if (state_q == ST_CTRL_ACK) begin
                            rx_dc_d = shift_q[DC_BIT];
                        end
                    end
                end
                default: ; // IDLE and IGNORE only react to START/STOP
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            rx_dc_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_stop_q  <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_dc_q    <= rx_dc_d;
            rx_valid_q <= rx_valid_d;
            rx_stop_q  <= rx_stop_d;
            addr_err_q <= addr_err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_dc    = rx_dc_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_stop  = rx_stop_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_iic_slave_rx
// Self-checking bench for iic_slave_rx: a bit-banged I2C master with an
// open-drain SDA model, and a monitor recording rx_valid data, rx_stop,
// addr_err and sda_oe assertions on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_iic_slave_rx;
    import iic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sda_m = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    iic_slave_rx_if bus ();

    // Open-drain bus: low if either the master or the responder pulls it.
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    iic_slave_rx #(.SLAVE_ADDR(8'h78), .FILT_LEN(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Monitor (samples on the falling edge, away from the active edge)
    logic [7:0] mon_data [0:63];
    logic       mon_dc   [0:63];
    int         n_valid  = 0;
    int         n_stop   = 0;
    int         n_aerr   = 0;
    int         n_oe     = 0;
    int         n_addr_st = 0;
    logic       oe_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                if (n_valid < 64) begin
                    mon_data[n_valid] = bus.rx_data;
                    mon_dc[n_valid]   = bus.rx_dc;
                end
                n_valid = n_valid + 1;
            end
            if (bus.rx_stop)  n_stop = n_stop + 1;
            if (bus.addr_err) n_aerr = n_aerr + 1;
            if (bus.sda_oe && !oe_prev) n_oe = n_oe + 1;
            if (dut.state_q == ST_ADDR) n_addr_st = n_addr_st + 1;
        end
        oe_prev = bus.sda_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master primitives; all phases are 12 clk, SDA changes 4 clk after SCL falls.
    task automatic i2c_start();
        tick(4); sda_m = 1'b1;
        tick(8); bus.scl = 1'b1;
        tick(12); sda_m = 1'b0;
        tick(12); bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(4); sda_m = 1'b0;
        tick(8); bus.scl = 1'b1;
        tick(12); sda_m = 1'b1;
        tick(12);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            tick(4); sda_m = b[i];
            tick(8); bus.scl = 1'b1;
            tick(12); bus.scl = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        tick(4); sda_m = 1'b1;
        tick(8); bus.scl = 1'b1;
        tick(6); ack = ~bus.sda_in;
        tick(6); bus.scl = 1'b0;
    endtask

    task automatic test_reset();
        bus.scl = 1'b1; sda_m = 1'b1; rst = 1'b1;
        tick(3);
        rst = 1'b0;
        n_checks++;
        if ({bus.sda_oe, bus.rx_data, bus.rx_dc, bus.rx_valid, bus.rx_stop, bus.addr_err, bus.busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got oe=%b data=%h dc=%b v=%b stop=%b aerr=%b busy=%b expected all 0",
                     bus.sda_oe, bus.rx_data, bus.rx_dc, bus.rx_valid, bus.rx_stop, bus.addr_err, bus.busy);
        end
        tick(10);
        n_checks++;
        if (bus.sda_in !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_bus: got sda=%b busy=%b expected sda=1 busy=0", bus.sda_in, bus.busy);
        end
    endtask

    // Write addr, control byte, one data byte, STOP; expect ACKs and one rx_valid.
    task automatic test_single(input string name, input logic [7:0] ctrl,
                               input logic [7:0] data, input logic exp_dc);
        logic [2:0] acks;
        logic a;
        int v0, s0, o0;
        v0 = n_valid; s0 = n_stop; o0 = n_oe;
        i2c_start();
        write_byte(8'h78, a); acks[2] = a;
        write_byte(ctrl, a);  acks[1] = a;
        write_byte(data, a);  acks[0] = a;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: got %b expected 1", name, bus.busy);
        end
        i2c_stop();
        n_checks++;
        if (acks !== 3'b111 || n_oe - o0 != 3) begin
            n_fail++;
            $display("FAIL %s_acks: got acks=%b oe_pulses=%0d expected 111 and 3", name, acks, n_oe - o0);
        end
        n_checks++;
        if (n_valid - v0 != 1) begin
            n_fail++;
            $display("FAIL %s_valid_count: got %0d expected 1", name, n_valid - v0);
        end else begin
            n_checks++;
            if (mon_data[v0] !== data || mon_dc[v0] !== exp_dc) begin
                n_fail++;
                $display("FAIL %s_data: got %h dc=%b expected %h dc=%b", name, mon_data[v0], mon_dc[v0], data, exp_dc);
            end
        end
        n_checks++;
        if (n_stop - s0 != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stop: got stops=%0d busy=%b expected 1 and 0", name, n_stop - s0, bus.busy);
        end
    endtask

    task automatic test_wrong_addr();
        logic [2:0] acks;
        logic a;
        int v0, s0, o0, e0;
        v0 = n_valid; s0 = n_stop; o0 = n_oe; e0 = n_aerr;
        i2c_start();
        write_byte(8'h7A, a);     acks[2] = a;
        write_byte(CTRL_DATA, a); acks[1] = a;
        write_byte(8'h11, a);     acks[0] = a;
        i2c_stop();
        n_checks++;
        if (acks !== 3'b000 || n_oe != o0) begin
            n_fail++;
            $display("FAIL wrong_addr_nack: got acks=%b oe_pulses=%0d expected 000 and 0", acks, n_oe - o0);
        end
        n_checks++;
        if (n_aerr - e0 != 1) begin
            n_fail++;
            $display("FAIL wrong_addr_err: got %0d expected 1", n_aerr - e0);
        end
        n_checks++;
        if (n_valid != v0 || n_stop != s0) begin
            n_fail++;
            $display("FAIL wrong_addr_quiet: got valid=%0d stop=%0d expected 0 and 0", n_valid - v0, n_stop - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [7:0] exp_d [3];
        int v0;
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
        v0 = n_valid;
        i2c_start();
        write_byte(8'h78, a);
        write_byte(CTRL_DATA, a);
        for (int i = 0; i < 3; i++) write_byte(exp_d[i], a);
        i2c_stop();
        n_checks++;
        if (n_valid - v0 != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 3", n_valid - v0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (mon_data[v0 + i] !== exp_d[i] || mon_dc[v0 + i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_byte%0d: got %h dc=%b expected %h dc=1", i, mon_data[v0 + i], mon_dc[v0 + i], exp_d[i]);
                end
            end
        end
    endtask

    // Repeated START in the middle of a data byte drops the partial byte.
    task automatic test_repeated_start();
        logic a;
        int v0;
        v0 = n_valid;
        i2c_start();
        write_byte(8'h78, a);
        write_byte(CTRL_DATA, a);
        write_bits(8'hE0, 3);
        i2c_start();
        write_byte(8'h78, a);
        write_byte(CTRL_CMD, a);
        write_byte(8'h55, a);
        i2c_stop();
        n_checks++;
        if (n_valid - v0 != 1 || mon_data[v0] !== 8'h55 || mon_dc[v0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstart_data: got count=%0d data=%h dc=%b expected 1, 55, 0", n_valid - v0, mon_data[v0], mon_dc[v0]);
        end
    endtask

    task automatic test_mid_reset();
        logic a;
        int v0;
        i2c_start();
        write_byte(8'h78, a);
        write_byte(CTRL_DATA, a);
        write_bits(8'hF0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++;
        if ({bus.sda_oe, bus.rx_data, bus.rx_dc, bus.rx_valid, bus.rx_stop, bus.addr_err, bus.busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got oe=%b data=%h dc=%b v=%b stop=%b aerr=%b busy=%b expected all 0",
                     bus.sda_oe, bus.rx_data, bus.rx_dc, bus.rx_valid, bus.rx_stop, bus.addr_err, bus.busy);
        end
        sda_m = 1'b1;
        tick(4); bus.scl = 1'b1;
        tick(12);
        v0 = n_valid;
        i2c_start();
        write_byte(8'h78, a);
        write_byte(CTRL_CMD, a);
        write_byte(8'hAF, a);
        i2c_stop();
        n_checks++;
        if (n_valid - v0 != 1 || bus.rx_data !== 8'hAF || bus.rx_dc !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover: got count=%0d data=%h dc=%b expected 1, af, 0", n_valid - v0, bus.rx_data, bus.rx_dc);
        end
    endtask

    // 2-clk SDA low pulse while SCL is high.
    task automatic test_glitch();
        int a0, s0;
        a0 = n_addr_st; s0 = n_stop;
        tick(12);
        sda_m = 1'b0;
        tick(2);
        sda_m = 1'b1;
        tick(20);
        n_checks++;
`ifdef IIC_GLITCH_FILTER_EN
        if (n_addr_st != a0) begin
            n_fail++;
            $display("FAIL glitch_filtered: got %0d ADDR cycles expected 0", n_addr_st - a0);
        end
`else
        if (n_addr_st == a0) begin
            n_fail++;
            $display("FAIL glitch_unfiltered: got %0d ADDR cycles expected >0", n_addr_st - a0);
        end
`endif
        n_checks++;
        if (dut.state_q !== ST_IDLE || n_stop != s0) begin
            n_fail++;
            $display("FAIL glitch_end_idle: got state=%0d stops=%0d expected IDLE and 0", dut.state_q, n_stop - s0);
        end
    endtask

    initial begin
        bus.scl = 1'b1;
        test_reset();
        test_single("data", CTRL_DATA, 8'hA5, 1'b1);
        test_single("cmd",  CTRL_CMD,  8'hAE, 1'b0);
        test_wrong_addr();
        test_back_to_back();
        test_repeated_start();
        test_mid_reset();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
